// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and the rest of the runner:
// raw buttons, frame strobe and sprite pixels in; run state, frame tick,
// jump request, score and speed level out.
interface game_ctrl_if;
    logic        fresh;
    logic        START;
    logic        button_jump;
    logic        px_dino;
    logic        px_obst;
    logic        game_status;
    logic        game_over;
    logic        frame_tick;
    logic        jump_req;
    logic [13:0] score;
    logic [2:0]  level;

    // Environment side: drives buttons, strobe and pixels, observes results
    modport master (
        output fresh, START, button_jump, px_dino, px_obst,
        input  game_status, game_over, frame_tick, jump_req, score, level
    );

    // Sequencer side
    modport slave (
        input  fresh, START, button_jump, px_dino, px_obst,
        output game_status, game_over, frame_tick, jump_req, score, level
    );
endinterface

// File: rtl/game_ctrl.sv
// Game sequencer for the dinosaur runner: conditions the raw buttons and
// frame strobe, runs the IDLE/RUN/OVER flow, latches sprite collisions,
// produces a frame-aligned jump request and keeps score and speed level.
module game_ctrl #(
    parameter int SCORE_DIV = 6,
    parameter int LEVEL_PTS = 100,
    parameter int MAX_LEVEL = 7,
    parameter int OVER_HOLD = 60
) (
    input  logic        clk,
    input  logic        RESET_n,
    game_ctrl_if.slave  bus
);

    localparam int FRAME_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int PTS_W   = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;
    localparam int HOLD_W  = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
    localparam logic [13:0] SCORE_MAX = 14'h3FFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t              state;
    logic [2:0]          fresh_sync;
    logic [2:0]          start_sync;
    logic [2:0]          jump_sync;
    logic                tick;
    logic                start_evt;
    logic                jump_evt;
    logic                running;
    logic                finished;
    logic                jump_pend;
    logic                jump_seen;
    logic                coll;
    logic [13:0]         score_cnt;
    logic [2:0]          level_cnt;
    logic [FRAME_W-1:0]  frame_cnt;
    logic [PTS_W-1:0]    pts_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                hit;
    logic                go_run;

    assign hit    = bus.px_dino & bus.px_obst;
    assign go_run = start_evt &&
                    ((state == IDLE) ||
                     ((state == OVER) && (hold_cnt == HOLD_W'(OVER_HOLD))));

    assign bus.game_status = running;
    assign bus.game_over   = finished;
    assign bus.frame_tick  = tick;
    assign bus.jump_req    = jump_pend;
    assign bus.score       = score_cnt;
    assign bus.level       = level_cnt;

    // Two-stage synchronizers plus one history stage, and registered edge pulses
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            fresh_sync <= '0;
            start_sync <= '0;
            jump_sync  <= '0;
            tick       <= 1'b0;
            start_evt  <= 1'b0;
            jump_evt   <= 1'b0;
        end else begin
            fresh_sync <= {fresh_sync[1:0], bus.fresh};
            start_sync <= {start_sync[1:0], bus.START};
            jump_sync  <= {jump_sync[1:0], bus.button_jump};
            tick       <= fresh_sync[2] & ~fresh_sync[1];
            start_evt  <= ~start_sync[2] & start_sync[1];
            jump_evt   <= ~jump_sync[2] & jump_sync[1];
        end
    end

    // Game flow, collision latch, jump request, scoring and over-hold counting
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= IDLE;
            running   <= 1'b0;
            finished  <= 1'b0;
            jump_pend <= 1'b0;
            jump_seen <= 1'b0;
            coll      <= 1'b0;
            score_cnt <= '0;
            level_cnt <= '0;
            frame_cnt <= '0;
            pts_cnt   <= '0;
            hold_cnt  <= '0;
        end else if (go_run) begin
            state     <= RUN;
            running   <= 1'b1;
            finished  <= 1'b0;
            jump_pend <= 1'b0;
            jump_seen <= 1'b0;
            coll      <= 1'b0;
            score_cnt <= '0;
            level_cnt <= '0;
            frame_cnt <= '0;
            pts_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    running   <= 1'b0;
                    finished  <= 1'b0;
                    jump_pend <= 1'b0;
                end
                RUN: begin
                    if (hit) begin
                        coll <= 1'b1;
                    end
                    if (jump_evt && !jump_pend) begin
                        jump_pend <= 1'b1;
                        jump_seen <= 1'b0;
                    end
                    if (tick) begin
                        coll <= 1'b0;
                        if (coll | hit) begin
                            state     <= OVER;
                            running   <= 1'b0;
                            finished  <= 1'b1;
                            jump_pend <= 1'b0;
                            jump_seen <= 1'b0;
                            hold_cnt  <= '0;
                        end else begin
                            if (jump_pend) begin
                                if (jump_seen) begin
                                    jump_pend <= 1'b0;
                                    jump_seen <= 1'b0;
                                end else begin
                                    jump_seen <= 1'b1;
                                end
                            end
                            if (frame_cnt == FRAME_W'(SCORE_DIV - 1)) begin
                                frame_cnt <= '0;
                                if (score_cnt != SCORE_MAX) begin
                                    score_cnt <= score_cnt + 14'd1;
                                    if (pts_cnt == PTS_W'(LEVEL_PTS - 1)) begin
                                        pts_cnt <= '0;
                                        if (level_cnt != 3'(MAX_LEVEL)) begin
                                            level_cnt <= level_cnt + 3'd1;
                                        end
                                    end else begin
                                        pts_cnt <= pts_cnt + 1'b1;
                                    end
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                end
                OVER: begin
                    if (tick && (hold_cnt != HOLD_W'(OVER_HOLD))) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    running  <= 1'b0;
                    finished <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl. A frame-level model tracks game state,
// frames survived, over-hold frames and remaining jump frames; score and
// level are derived from frames survived with plain division.
module tb_game_ctrl;

    localparam int SCORE_DIV = 6;
    localparam int LEVEL_PTS = 2;
    localparam int MAX_LEVEL = 7;
    localparam int OVER_HOLD = 60;

    logic clk = 1'b0;
    logic rst_n;

    game_ctrl_if bus ();

    game_ctrl #(
        .SCORE_DIV (SCORE_DIV),
        .LEVEL_PTS (LEVEL_PTS),
        .MAX_LEVEL (MAX_LEVEL),
        .OVER_HOLD (OVER_HOLD)
    ) dut (
        .clk     (clk),
        .RESET_n (rst_n),
        .bus     (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 idle, 1 running, 2 game over
    int m_state  = 0;
    int m_frames = 0;
    int m_hold   = 0;
    int m_jl     = 0;

    function automatic int exp_score(input int frames);
        int s;
        s = frames / SCORE_DIV;
        return (s > 16383) ? 16383 : s;
    endfunction

    function automatic int exp_level(input int frames);
        int l;
        l = exp_score(frames) / LEVEL_PTS;
        return (l > MAX_LEVEL) ? MAX_LEVEL : l;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, "/status"}, 32'(bus.game_status), 32'(m_state == 1));
        check({tag, "/over"},   32'(bus.game_over),   32'(m_state == 2));
        check({tag, "/jump"},   32'(bus.jump_req),    32'(m_jl > 0));
        check({tag, "/score"},  32'(bus.score),       32'(exp_score(m_frames)));
        check({tag, "/level"},  32'(bus.level),       32'(exp_level(m_frames)));
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_frames = 0;
        m_hold   = 0;
        m_jl     = 0;
    endtask

    // One frame: fresh high with stray single-sprite pixels (optionally one overlap), then fresh falls
    task automatic run_frame(input bit collide);
        int hi;
        int hit_at;
        int r;
        hi     = $urandom_range(5, 10);
        hit_at = $urandom_range(1, hi - 2);
        bus.fresh = 1'b1;
        for (int i = 0; i < hi; i++) begin
            if (collide && i == hit_at) begin
                bus.px_dino = 1'b1;
                bus.px_obst = 1'b1;
            end else begin
                r = $urandom_range(0, 2);
                bus.px_dino = (r == 1);
                bus.px_obst = (r == 2);
            end
            step(1);
        end
        bus.px_dino = 1'b0;
        bus.px_obst = 1'b0;
        bus.fresh   = 1'b0;
        step($urandom_range(6, 9));
        if (m_state == 1) begin
            if (collide) begin
                m_state = 2;
                m_hold  = 0;
                m_jl    = 0;
            end else begin
                m_frames++;
                if (m_jl > 0) m_jl--;
            end
        end else if (m_state == 2) begin
            if (m_hold < OVER_HOLD) m_hold++;
        end
    endtask

    task automatic press_start();
        bus.START = 1'b1;
        step(2);
        bus.START = 1'b0;
        step(4);
        if (m_state == 0 || (m_state == 2 && m_hold >= OVER_HOLD)) begin
            m_state  = 1;
            m_frames = 0;
            m_jl     = 0;
        end
    endtask

    task automatic press_jump();
        bus.button_jump = 1'b1;
        step(2);
        bus.button_jump = 1'b0;
        step(4);
        if (m_state == 1 && m_jl == 0) m_jl = 2;
    endtask

    task automatic apply_stimulus(input int frames, input string tag);
        for (int i = 0; i < frames; i++) begin
            if ($urandom_range(0, 3) == 0) press_jump();
            run_frame(1'b0);
            check_output(tag);
        end
    endtask

    // Directed sequence of steps with randomized timing and jumps
    initial begin
        rst_n           = 1'b0;
        bus.fresh       = 1'b0;
        bus.START       = 1'b0;
        bus.button_jump = 1'b0;
        bus.px_dino     = 1'b0;
        bus.px_obst     = 1'b0;
        model_reset();

        $display("[TB] reset state");
        step(3);
        check("rst/tick", 32'(bus.frame_tick), 32'd0);
        check_output("rst");
        rst_n = 1'b1;
        step(2);

        $display("[TB] jump and overlap in IDLE");
        press_jump();
        check("idle_jump", 32'(bus.jump_req), 32'd0);
        run_frame(1'b1);
        check_output("idle_hit");

        $display("[TB] start latency");
        bus.START = 1'b1;
        step(2);
        bus.START = 1'b0;
        step(1);
        check("start_lat3", 32'(bus.game_status), 32'd0);
        step(1);
        check("start_lat4", 32'(bus.game_status), 32'd1);
        m_state  = 1;
        m_frames = 0;
        m_jl     = 0;
        check_output("start");

        $display("[TB] frame tick latency");
        bus.fresh = 1'b1;
        step(5);
        bus.fresh = 1'b0;
        step(2);
        check("tick_lat2", 32'(bus.frame_tick), 32'd0);
        step(1);
        check("tick_lat3", 32'(bus.frame_tick), 32'd1);
        step(1);
        check("tick_lat4", 32'(bus.frame_tick), 32'd0);
        step(4);
        m_frames++;
        if (m_jl > 0) m_jl--;

        $display("[TB] scoring");
        apply_stimulus(59, "run60");
        check("score60", 32'(bus.score), 32'd10);
        check("level60", 32'(bus.level), 32'd5);
        apply_stimulus(30, "run90");
        check("score90", 32'(bus.score), 32'd15);
        check("level90", 32'(bus.level), 32'd7);

        $display("[TB] jump request timing");
        run_frame(1'b0);
        run_frame(1'b0);
        check_output("jump_idle");
        bus.button_jump = 1'b1;
        step(2);
        bus.button_jump = 1'b0;
        step(1);
        check("jump_lat3", 32'(bus.jump_req), 32'd0);
        step(1);
        check("jump_lat4", 32'(bus.jump_req), 32'd1);
        m_jl = 2;
        step(2);
        press_jump();
        run_frame(1'b0);
        check("jump_frame1", 32'(bus.jump_req), 32'd1);
        run_frame(1'b0);
        check("jump_frame2", 32'(bus.jump_req), 32'd0);
        check_output("jump_done");

        $display("[TB] collision");
        press_jump();
        run_frame(1'b1);
        check("coll_over", 32'(bus.game_over), 32'd1);
        check_output("coll");

        $display("[TB] over hold");
        for (int i = 0; i < 10; i++) run_frame(i[0]);
        press_start();
        check_output("hold10");
        for (int i = 0; i < 49; i++) run_frame(i[1]);
        press_start();
        check("hold59_over", 32'(bus.game_over), 32'd1);
        check_output("hold59");
        run_frame(1'b1);
        press_start();
        check("restart_status", 32'(bus.game_status), 32'd1);
        check("restart_score", 32'(bus.score), 32'd0);
        check("restart_level", 32'(bus.level), 32'd0);
        run_frame(1'b0);
        check_output("restart_latch");

        $display("[TB] long run and reset mid-run");
        while (m_frames < 222) apply_stimulus(1, "long");
        if (m_jl == 0) press_jump();
        check("long_score", 32'(bus.score), 32'd37);
        check("long_jump", 32'(bus.jump_req), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_tick", 32'(bus.frame_tick), 32'd0);
        check_output("async_rst");
        step(2);
        rst_n = 1'b1;
        step(2);
        check_output("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
